register_file_mp: RTL and testbench

//   Multi-ported, parametrised MIPS register file for the dual-issue pipeline.
//   NUM_RD combinational read ports, NUM_WR write ports with fixed priority,

---
 rtl/register_file_mp.sv | 110 +++++++++++
 tb/tb_register_file_mp.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-ported register file for the dual-issue MIPS pipeline.
// Provides combinational reads with optional write forwarding, prioritised
// write ports and a per-register busy scoreboard for decode hazard stalls.
// Register 0 always reads zero, drops writes and is never busy.
module register_file_mp #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_COUNT      = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD         = 4,
    parameter int unsigned NUM_WR         = 2,
    parameter int unsigned BYPASS         = 1
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]           rd_data_o,
    output logic [NUM_RD-1:0]                rd_busy_o,
    input  logic [NUM_WR-1:0]                wr_en_i,
    input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0]           wr_data_i,
    input  logic                             sb_set_i,
    input  logic [REG_ADDR_WIDTH-1:0]        sb_addr_i,
    input  logic                             flush_i,
    output logic                             any_busy_o
);

    localparam int unsigned AW      = REG_ADDR_WIDTH;
    localparam int unsigned RegSpan = 1 << REG_ADDR_WIDTH;

    logic [XLEN-1:0]      regs_q [REG_COUNT];
    logic [XLEN-1:0]      regs_d [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;

    // Addresses index the array directly, so every encodable address must exist.
    assert property (@(posedge clk_i) REG_COUNT == RegSpan)
        else $error("register_file_mp: REG_COUNT must equal 2**REG_ADDR_WIDTH");

    // Value seen by a read of address a: zero for r0, else the highest-index
    // matching same-cycle write when forwarding is enabled, else the array.
    function automatic logic [XLEN-1:0] read_value(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = regs_q[a];
        if (BYPASS != 0) begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == a)) begin
                    v = wr_data_i[w*XLEN +: XLEN];
                end
            end
        end
        if (a == '0) begin
            v = '0;
        end
        return v;
    endfunction

    // Array next state: later (higher-index) ports overwrite earlier ones.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w]) begin
                regs_d[wr_addr_i[w*AW +: AW]] = wr_data_i[w*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    // Scoreboard next state: writeback clears, issue sets, flush clears all.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w]) begin
                busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (sb_set_i) begin
            busy_d[sb_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports; busy is registered state only, never forwarded.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            if (reset_ni) begin
                rd_data_o[p*XLEN +: XLEN] = read_value(rd_addr_i[p*AW +: AW]);
                rd_busy_o[p]              = busy_q[rd_addr_i[p*AW +: AW]];
            end
        end
    end

    assign any_busy_o = reset_ni & (|busy_q);

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed scenarios followed by
// randomized traffic compared against an array-based behavioural model.
module tb_register_file_mp;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RC     = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned NUM_RD = 4;
    localparam int unsigned NUM_WR = 2;
    localparam int unsigned BYPASS = 1;

    logic                      clk;
    logic                      reset_n;
    logic [NUM_RD*AW-1:0]      rd_addr;
    logic [NUM_RD*XLEN-1:0]    rd_data;
    logic [NUM_RD-1:0]         rd_busy;
    logic [NUM_WR-1:0]         wr_en;
    logic [NUM_WR*AW-1:0]      wr_addr;
    logic [NUM_WR*XLEN-1:0]    wr_data;
    logic                      sb_set;
    logic [AW-1:0]             sb_addr;
    logic                      flush;
    logic                      any_busy;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: architectural contents and busy flags.
    logic [XLEN-1:0] m_regs [RC];
    bit              m_busy [RC];

    register_file_mp #(
        .XLEN          (XLEN),
        .REG_COUNT     (RC),
        .REG_ADDR_WIDTH(AW),
        .NUM_RD        (NUM_RD),
        .NUM_WR        (NUM_WR),
        .BYPASS        (BYPASS)
    ) dut (
        .clk_i     (clk),
        .reset_ni  (reset_n),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .rd_busy_o (rd_busy),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .sb_set_i  (sb_set),
        .sb_addr_i (sb_addr),
        .flush_i   (flush),
        .any_busy_o(any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] port_data(int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    task automatic set_rd(int p, int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(int w, bit en, int a, logic [XLEN-1:0] d);
        wr_en[w]               = en;
        wr_addr[w*AW +: AW]    = AW'(a);
        wr_data[w*XLEN +: XLEN] = d;
    endtask

    task automatic quiet();
        wr_en  = '0;
        sb_set = 1'b0;
        flush  = 1'b0;
    endtask

    // Expected read: zero in reset or for r0; newest same-cycle write wins.
    function automatic logic [XLEN-1:0] model_read(int a);
        if (!reset_n || a == 0) return '0;
        if (BYPASS != 0) begin
            for (int w = NUM_WR - 1; w >= 0; w--) begin
                if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) return wr_data[w*XLEN +: XLEN];
            end
        end
        return m_regs[a];
    endfunction

    function automatic bit model_any();
        bit r = 1'b0;
        for (int i = 0; i < RC; i++) r |= m_busy[i];
        return reset_n && r;
    endfunction

    // Advance one clock edge and apply the architectural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < RC; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] != 0) begin
                    m_regs[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
                    m_busy[wr_addr[w*AW +: AW]] = 1'b0;
                end
            end
            if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
            if (flush) begin
                for (int i = 0; i < RC; i++) m_busy[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        quiet();
        reset_n = 1'b1;
        set_wr(0, 1'b1, 5, 32'hDEAD_BEEF);
        sb_set = 1'b1; sb_addr = 5'd5;
        tick();
        quiet();
        set_rd(0, 5);
        #1;
        checks++;
        if (port_data(0) !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL reset_prewrite: got %h want %h", port_data(0), 32'hDEAD_BEEF);
        end
        reset_n = 1'b0;
        set_wr(0, 1'b1, 6, 32'h1234_5678);
        sb_set = 1'b1; sb_addr = 5'd7;
        set_rd(1, 6);
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== '0 || any_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_forced: data %h busy %b any %b want all zero",
                     rd_data, rd_busy, any_busy);
        end
        tick();
        reset_n = 1'b1;
        quiet();
        set_rd(2, 7);
        #1;
        checks++;
        if (port_data(0) !== 32'h0 || port_data(1) !== 32'h0) begin
            failures++;
            $display("FAIL reset_clear: r5 %h r6 %h want 0", port_data(0), port_data(1));
        end
        checks++;
        if (any_busy !== 1'b0 || rd_busy !== '0) begin
            failures++;
            $display("FAIL reset_busy: any %b rd_busy %b want 0", any_busy, rd_busy);
        end
    endtask

    task automatic test_zero_reg();
        quiet();
        set_wr(0, 1'b1, 0, 32'hFFFF_FFFF);
        sb_set = 1'b1; sb_addr = 5'd0;
        set_rd(0, 0);
        #1;
        checks++;
        if (port_data(0) !== 32'h0) begin
            failures++;
            $display("FAIL zero_same_cycle: got %h want 0", port_data(0));
        end
        tick();
        quiet();
        #1;
        checks++;
        if (port_data(0) !== 32'h0 || rd_busy[0] !== 1'b0 || any_busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_after: data %h busy %b any %b want 0 0 0",
                     port_data(0), rd_busy[0], any_busy);
        end
    endtask

    task automatic test_conflict();
        quiet();
        set_wr(0, 1'b1, 7, 32'h11);
        set_wr(1, 1'b1, 7, 32'h22);
        set_rd(0, 7);
        #1;
        checks++;
        if (port_data(0) !== (BYPASS != 0 ? 32'h22 : 32'h0)) begin
            failures++;
            $display("FAIL conflict_bypass: got %h want %h", port_data(0),
                     (BYPASS != 0 ? 32'h22 : 32'h0));
        end
        tick();
        quiet();
        #1;
        checks++;
        if (port_data(0) !== 32'h22) begin
            failures++;
            $display("FAIL conflict_stored: got %h want %h", port_data(0), 32'h22);
        end
    endtask

    task automatic test_bypass();
        quiet();
        set_wr(1, 1'b1, 9, 32'h1);
        tick();
        quiet();
        set_wr(0, 1'b1, 9, 32'h55);
        for (int p = 0; p < NUM_RD; p++) set_rd(p, 9);
        #1;
        for (int p = 0; p < NUM_RD; p++) begin
            checks++;
            if (port_data(p) !== (BYPASS != 0 ? 32'h55 : 32'h1)) begin
                failures++;
                $display("FAIL bypass_port%0d: got %h want %h", p, port_data(p),
                         (BYPASS != 0 ? 32'h55 : 32'h1));
            end
        end
        tick();
        quiet();
        #1;
        checks++;
        if (port_data(3) !== 32'h55) begin
            failures++;
            $display("FAIL bypass_stored: got %h want %h", port_data(3), 32'h55);
        end
    endtask

    task automatic test_scoreboard();
        quiet();
        set_rd(0, 3);
        sb_set = 1'b1; sb_addr = 5'd3;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL sb_before: got %b want 0", rd_busy[0]);
        end
        tick();
        quiet();
        set_wr(1, 1'b1, 3, 32'hA5);
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || any_busy !== 1'b1) begin
            failures++;
            $display("FAIL sb_set: busy %b any %b want 1 1", rd_busy[0], any_busy);
        end
        tick();
        quiet();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || any_busy !== 1'b0) begin
            failures++;
            $display("FAIL sb_clear: busy %b any %b want 0 0", rd_busy[0], any_busy);
        end
        sb_set = 1'b1; sb_addr = 5'd3;
        set_wr(0, 1'b1, 3, 32'hB6);
        tick();
        quiet();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL sb_set_wins: got %b want 1", rd_busy[0]);
        end
    endtask

    task automatic test_flush();
        int regs_l [3] = '{3, 4, 8};
        quiet();
        for (int i = 0; i < 3; i++) begin
            sb_set = 1'b1; sb_addr = AW'(regs_l[i]);
            tick();
        end
        quiet();
        set_rd(0, 3); set_rd(1, 4); set_rd(2, 8); set_rd(3, 10);
        #1;
        checks++;
        if (rd_busy !== 4'b0111 || any_busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_setup: busy %b any %b want 0111 1", rd_busy, any_busy);
        end
        flush = 1'b1;
        sb_set = 1'b1; sb_addr = 5'd10;
        set_wr(0, 1'b1, 4, 32'h7);
        tick();
        quiet();
        #1;
        checks++;
        if (rd_busy !== 4'b0000 || any_busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy: busy %b any %b want 0000 0", rd_busy, any_busy);
        end
        checks++;
        if (port_data(1) !== 32'h7) begin
            failures++;
            $display("FAIL flush_write: got %h want %h", port_data(1), 32'h7);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                set_wr(w, bit'($urandom_range(0, 1)), int'($urandom_range(0, RC - 1)), $urandom);
            end
            sb_set  = ($urandom_range(0, 2) == 0);
            sb_addr = AW'($urandom_range(0, RC - 1));
            flush   = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NUM_RD; p++) begin
                if ($urandom_range(0, 2) == 0)
                    set_rd(p, int'(wr_addr[($urandom_range(0, NUM_WR - 1))*AW +: AW]));
                else
                    set_rd(p, int'($urandom_range(0, RC - 1)));
            end
            #1;
            for (int p = 0; p < NUM_RD; p++) begin
                int a;
                a = int'(rd_addr[p*AW +: AW]);
                checks++;
                if (port_data(p) !== model_read(a)) begin
                    failures++;
                    $display("FAIL rand_data c%0d p%0d r%0d: got %h want %h", cyc, p, a,
                             port_data(p), model_read(a));
                end
                checks++;
                if (rd_busy[p] !== m_busy[a]) begin
                    failures++;
                    $display("FAIL rand_busy c%0d p%0d r%0d: got %b want %b", cyc, p, a,
                             rd_busy[p], m_busy[a]);
                end
            end
            checks++;
            if (any_busy !== model_any()) begin
                failures++;
                $display("FAIL rand_any c%0d: got %b want %b", cyc, any_busy, model_any());
            end
            tick();
        end
        quiet();
    endtask

    initial begin
        reset_n = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        sb_addr = '0;
        quiet();
        for (int i = 0; i < RC; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        @(negedge clk);
        tick();
        tick();
        test_reset();
        test_zero_reg();
        test_conflict();
        test_bypass();
        test_scoreboard();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
